// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: drives the instruction ROM, buffers {pc, inst} pairs
// in a small FIFO and hands them to IF/ID over a valid/ready handshake.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_ce,
    output logic [31:0]              rom_addr,
    input  logic [31:0]              rom_inst,
    input  logic                     br_valid,
    input  logic [31:0]              br_target,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_inst,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_mem_pc   [DEPTH];
    logic [31:0]     r_mem_inst [DEPTH];

    logic            w_push;
    logic            w_pop;
    logic            w_unused;

    // A redirect cancels both sides of the handshake in the cycle it arrives.
    assign w_push   = (r_state == FETCH) && !br_valid;
    assign w_pop    = id_valid && id_ready && !br_valid;
    assign w_unused = ^br_target[1:0];

    assign rom_ce   = (r_state == FETCH);
    assign rom_addr = rom_ce ? r_fetch_pc : 32'h0;
    assign id_valid = (r_count != '0);
    assign id_pc    = id_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;
    assign id_inst  = id_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
    assign fq_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (br_valid) begin
            r_state    <= FETCH;
            r_fetch_pc <= {br_target[31:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            // HOLD is entered on the push that fills the last slot, so FETCH never overflows.
            case (r_state)
                IDLE:    r_state <= FETCH;
                FETCH:   if (w_push && !w_pop && r_count == CW'(DEPTH - 1)) r_state <= HOLD;
                HOLD:    if (w_pop) r_state <= FETCH;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
            r_mem_inst[r_wr_ptr] <= rom_inst;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a queue-level reference model predicts the
// ROM/count outputs, and a scoreboard checks every entry handed to ID.
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   rom_ce;
    logic [31:0]            rom_addr;
    logic [31:0]            rom_inst;
    logic                   br_valid = 1'b0;
    logic [31:0]            br_target = 32'h0;
    logic                   id_ready = 1'b0;
    logic                   id_valid;
    logic [31:0]            id_pc;
    logic [31:0]            id_inst;
    logic [$clog2(DEPTH):0] fq_count;

    int          tests = 0;
    int          fails = 0;
    entry_t      modelQ[$];
    entry_t      sbQ[$];
    logic [31:0] nextPc = 32'h0;
    bit          justReset = 1'b0;
    bit          modelValid = 1'b0;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .br_valid(br_valid), .br_target(br_target), .id_ready(id_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romWord(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    // Garbage when disabled, so a push with rom_ce low shows up in the scoreboard.
    assign rom_inst = rom_ce ? romWord(rom_addr) : 32'hDEAD_BEEF;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // The queue fetches whenever it is not in its post-reset idle cycle and has room.
    task automatic applyStimulus(input bit rstV, input bit brV, input logic [31:0] tgt, input bit rdy);
        bit fetching;
        bit doPop;
        entry_t e;
        @(negedge clk);
        rst = rstV;
        br_valid = brV;
        br_target = tgt;
        id_ready = rdy;
        #2;
        fetching = modelValid && !justReset && (modelQ.size() < DEPTH);
        if (modelValid) begin
            checkOutput("rom_ce", 32'(rom_ce), 32'(fetching));
            checkOutput("rom_addr", rom_addr, fetching ? nextPc : 32'h0);
            checkOutput("id_valid", 32'(id_valid), 32'(modelQ.size() != 0));
            checkOutput("fq_count", 32'(fq_count), 32'(modelQ.size()));
            if (modelQ.size() == 0) begin
                checkOutput("id_pc_idle", id_pc, 32'h0);
                checkOutput("id_inst_idle", id_inst, 32'h0);
            end
        end
        if (rstV) begin
            modelQ.delete();
            sbQ.delete();
            nextPc = RESET_PC;
            justReset = 1'b1;
            modelValid = 1'b1;
        end else if (modelValid && brV) begin
            modelQ.delete();
            sbQ.delete();
            nextPc = {tgt[31:2], 2'b00};
            justReset = 1'b0;
        end else if (modelValid) begin
            doPop = (modelQ.size() != 0) && rdy;
            if (doPop) void'(modelQ.pop_front());
            if (fetching) begin
                e.pc = nextPc;
                e.inst = romWord(nextPc);
                modelQ.push_back(e);
                sbQ.push_back(e);
                nextPc = nextPc + 32'd4;
            end
            justReset = 1'b0;
        end
    endtask

    task automatic runCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, rdy);
    endtask

    // Monitor: every accepted head entry must match the oldest outstanding expectation.
    always @(negedge clk) begin
        entry_t exp;
        #1;
        if (modelValid && rst === 1'b0 && br_valid === 1'b0 && id_valid === 1'b1 && id_ready === 1'b1) begin
            if (sbQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_entry: got pc %h, expected no entry at %0t", id_pc, $time);
            end else begin
                exp = sbQ.pop_front();
                checkOutput("id_pc", id_pc, exp.pc);
                checkOutput("id_inst", id_inst, exp.inst);
            end
        end
    end

    initial begin
        int bias;
        bit rstV;
        bit brV;
        logic [31:0] tgt;

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        runCycles(12, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        runCycles(8, 1'b0);
        runCycles(1, 1'b1);
        runCycles(4, 1'b0);
        runCycles(8, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        runCycles(4, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0043, 1'b1);
        runCycles(6, 1'b1);

        runCycles(8, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_2001, 1'b1);
        runCycles(6, 1'b1);

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        runCycles(6, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        runCycles(3, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0800, 1'b1);
        runCycles(6, 1'b1);

        bias = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) bias = (c % 300 == 0) ? 10 : ((c % 300 == 100) ? 50 : 90);
            rstV = ($urandom_range(0, 199) == 0);
            brV = ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            applyStimulus(rstV, brV, tgt, $urandom_range(0, 99) < bias);
        end
        runCycles(10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
